// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone pending requester wins,
// a tie goes to whoever did not win last time.
module rr_arb2 (
    input  logic [1:0] pending_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_valid_o = |pending_i;
        grant_id_o    = 1'b0;
        unique case (pending_i)
            2'b01:   grant_id_o = 1'b0;
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ~last_grant_i;
            default: grant_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one req/ack RAM port between two requesters, one transaction at a time.
// Optional WAIT timeout is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          rq0_read_req,
    input  logic          rq0_write_req,
    input  logic [AW-1:0] rq0_address,
    input  logic [DW-1:0] rq0_wdata,
    output logic [DW-1:0] rq0_rdata,
    output logic          rq0_read_ack,
    output logic          rq0_write_ack,

    input  logic          rq1_read_req,
    input  logic          rq1_write_req,
    input  logic [AW-1:0] rq1_address,
    input  logic [DW-1:0] rq1_wdata,
    output logic [DW-1:0] rq1_rdata,
    output logic          rq1_read_ack,
    output logic          rq1_write_ack,

    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read_req,
    output logic          mem_write_req,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_read_ack,
    input  logic          mem_write_ack,

    output logic          grant,
    output logic          busy,
    output logic          timeout_err
);

    state_e        state_q, state_d;
    logic          lastGrant_q;
    logic          grant_q;
    op_e           op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic [1:0]    pending;
    logic          grantValid;
    logic          grantId;
    logic          ackMatch;
    logic          timeoutHit;
    logic          captureRead;
    logic [DW-1:0] readData;

    assign pending = {rq1_read_req | rq1_write_req, rq0_read_req | rq0_write_req};

    rr_arb2 u_rr_arb2 (
        .pending_i     (pending),
        .last_grant_i  (lastGrant_q),
        .grant_valid_o (grantValid),
        .grant_id_o    (grantId)
    );

    // Acks for the other operation type are stray and must not end WAIT.
    assign ackMatch    = (op_q == OP_WRITE) ? mem_write_ack : mem_read_ack;
    assign captureRead = (state_q == WAIT) && (op_q == OP_READ) && (ackMatch || timeoutHit);
    assign readData    = ackMatch ? mem_rdata : DW'(TIMEOUT_DATA);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] waitCnt_q;
    logic          timeoutErr_q;

    assign timeoutHit  = (state_q == WAIT) && (waitCnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeoutErr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            if (state_q == WAIT) begin
                waitCnt_q <= waitCnt_q + CW'(1);
            end else begin
                waitCnt_q <= '0;
            end
            if (timeoutHit && !ackMatch) begin
                timeoutErr_q <= 1'b1;
            end
        end
    end
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
    assign timeoutHit       = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grantValid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ackMatch || timeoutHit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        rq0_read_ack  = 1'b0;
        rq0_write_ack = 1'b0;
        rq1_read_ack  = 1'b0;
        rq1_write_ack = 1'b0;
        busy          = (state_q != IDLE);
        unique case (state_q)
            ISSUE: begin
                mem_read_req  = (op_q == OP_READ);
                mem_write_req = (op_q == OP_WRITE);
            end
            RESP: begin
                rq0_read_ack  = !grant_q && (op_q == OP_READ);
                rq0_write_ack = !grant_q && (op_q == OP_WRITE);
                rq1_read_ack  =  grant_q && (op_q == OP_READ);
                rq1_write_ack =  grant_q && (op_q == OP_WRITE);
            end
            default: begin
            end
        endcase
    end

    // Transaction latches; a write wins when a requester raises both lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            if ((state_q == IDLE) && grantValid) begin
                grant_q     <= grantId;
                lastGrant_q <= grantId;
                if (grantId) begin
                    op_q    <= rq1_write_req ? OP_WRITE : OP_READ;
                    addr_q  <= rq1_address;
                    wdata_q <= rq1_wdata;
                end else begin
                    op_q    <= rq0_write_req ? OP_WRITE : OP_READ;
                    addr_q  <= rq0_address;
                    wdata_q <= rq0_wdata;
                end
            end
            if (captureRead) begin
                if (grant_q) begin
                    rdata1_q <= readData;
                end else begin
                    rdata0_q <= readData;
                end
            end
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign rq0_rdata   = rdata0_q;
    assign rq1_rdata   = rdata1_q;
    assign grant       = grant_q;

endmodule
